// File: rtl/counter_pkg.sv
// Package shared by the counter sequencer slice: direction encodings,
// default geometry and a Gray-code helper.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEFAULT_WIDTH = 2;
  localparam int DEFAULT_MOD   = 4;

  // Binary to reflected Gray code; callers truncate to their own width.
  function automatic logic [31:0] gray_code(input logic [31:0] value);
    return value ^ (value >> 1);
  endfunction

endpackage

// File: rtl/counter_seq_if.sv
// Snapshot port of the counter sequencer: a one-entry valid/ready buffer
// plus a sticky overflow flag raised when a request has to be dropped.
interface counter_seq_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             snap_req;
  logic             snap_ready;
  logic             snap_valid;
  logic [WIDTH-1:0] snap_data;
  logic             snap_ovf;

  // The sequencer owns the buffer and drives valid/data/ovf.
  modport master (
    input  snap_req,
    input  snap_ready,
    output snap_valid,
    output snap_data,
    output snap_ovf
  );

  // The consumer issues requests and accepts captured values.
  modport slave (
    output snap_req,
    output snap_ready,
    input  snap_valid,
    input  snap_data,
    input  snap_ovf
  );

endinterface

// File: rtl/counter_next.sv
// Combinational next-state stage of the modulo counter. Load beats
// enable; wrap-around is detected explicitly against MOD so that moduli
// smaller than 2**WIDTH behave correctly.
module counter_next
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = DEFAULT_MOD
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_dir,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_next
);

  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MOD);
  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  // Out-of-range load values collapse to zero rather than entering an
  // unreachable state; otherwise step up or down with explicit wrap.
  always_comb begin
    o_next = i_count;
    if (i_load) begin
      if ({1'b0, i_load_val} < MOD_EXT) begin
        o_next = i_load_val;
      end else begin
        o_next = ZERO;
      end
    end else if (i_en) begin
      if (i_dir == DIR_DOWN) begin
        o_next = (i_count == ZERO) ? MAX_VAL : i_count - ONE;
      end else begin
        o_next = (i_count == MAX_VAL) ? ZERO : i_count + ONE;
      end
    end
  end

endmodule

// File: rtl/counter_seq.sv
// Registered sequencer around counter_next: holds the count, raises a
// combinational terminal-count strobe on the wrapping cycle and keeps a
// one-entry snapshot buffer for a downstream consumer.
// Optional feature macro: COUNTER_GRAY_OUT_EN adds o_count_gray.
module counter_seq
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int MOD   = DEFAULT_MOD
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_dir,
  input  logic              i_load,
  input  logic [WIDTH-1:0]  i_load_val,
  output logic [WIDTH-1:0]  o_count,
  output logic              o_tc,
  counter_seq_if.master     snap
`ifdef COUNTER_GRAY_OUT_EN
  , output logic [WIDTH-1:0] o_count_gray
`endif
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] ZERO    = '0;

  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_next;
  logic             r_snapValid;
  logic [WIDTH-1:0] r_snapData;
  logic             r_snapOvf;
  logic             w_snapAccept;
  logic             w_snapDrop;

  counter_next #(
    .WIDTH (WIDTH),
    .MOD   (MOD)
  ) u_next (
    .i_count    (r_count),
    .i_dir      (i_dir),
    .i_load     (i_load),
    .i_load_val (i_load_val),
    .i_en       (i_en),
    .o_next     (w_next)
  );

  // Count register; reset wins over every other control.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= ZERO;
    end else begin
      r_count <= w_next;
    end
  end

  // Terminal count flags the cycle whose edge wraps the counter.
  always_comb begin
    o_tc = 1'b0;
    if (i_en && !i_load && !i_rst) begin
      o_tc = (i_dir == DIR_DOWN) ? (r_count == ZERO) : (r_count == MAX_VAL);
    end
  end

  // A request is taken when the buffer is empty or drained this cycle,
  // and dropped (with overflow noted) when the buffer is stuck full.
  always_comb begin
    w_snapAccept = snap.snap_req && (!r_snapValid || snap.snap_ready);
    w_snapDrop   = snap.snap_req && r_snapValid && !snap.snap_ready;
  end

  // Snapshot buffer captures the pre-edge count; overflow is sticky
  // until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_snapValid <= 1'b0;
      r_snapData  <= ZERO;
      r_snapOvf   <= 1'b0;
    end else begin
      if (w_snapAccept) begin
        r_snapValid <= 1'b1;
        r_snapData  <= r_count;
      end else if (snap.snap_ready) begin
        r_snapValid <= 1'b0;
      end
      if (w_snapDrop) begin
        r_snapOvf <= 1'b1;
      end
    end
  end

  assign o_count         = r_count;
  assign snap.snap_valid = r_snapValid;
  assign snap.snap_data  = r_snapData;
  assign snap.snap_ovf   = r_snapOvf;

`ifdef COUNTER_GRAY_OUT_EN
  assign o_count_gray = WIDTH'(gray_code(32'(r_count)));
`endif

endmodule
